repeat_timer: RTL

Parametrised cycle-count timer: a hardware version of "wait N clock edges, then signal completion". A requester loads a count over a valid/ready handshake, and the block counts rising clock edges. It then issues a one-cycle `done` pulse, either once (one-shot) or repeatedly with automatic reload (periodic). Used by testbench sequencers and control FSMs wherever a programmable edge delay is needed.

---
 rtl/repeat_timer_pkg.sv | 21 ++
 rtl/repeat_timer_prescaler.sv | 39 +++
 rtl/repeat_timer.sv | 115 +++++++++++
 3 files changed

// File: rtl/repeat_timer_pkg.sv
// repeat_timer_pkg: shared types and helpers for the repeat_timer block.
// Holds the FSM state enum, the one-shot/periodic mode enum and a helper
// that sizes the optional prescale counter.
package repeat_timer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } repeat_timer_state_e;

    typedef enum logic {
        ONE_SHOT = 1'b0,
        PERIODIC = 1'b1
    } repeat_timer_mode_e;

    // Width of a counter that has to hold values 0 .. p-1, never narrower than one bit.
    function automatic int prescale_width(input int p);
        return (p > 1) ? $clog2(p) : 1;
    endfunction

endpackage

// File: rtl/repeat_timer_prescaler.sv
// repeat_timer_prescaler: divides RUN edges down to count steps.
// Only instantiated by repeat_timer when REPEAT_TIMER_PRESCALE_EN is defined.
// 'step' is high on every PRESCALE-th edge while 'run' is high; 'clear'
// restarts the division so a fresh period always gets PRESCALE full edges.
module repeat_timer_prescaler
    import repeat_timer_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    output logic step
);

    localparam int PS_W = prescale_width(PRESCALE);
    localparam logic [PS_W-1:0] LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] cnt;

    assign step = run && (cnt == LAST);

    // Edge counter that wraps after PRESCALE RUN edges and restarts on clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (run) begin
            if (cnt == LAST) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + PS_W'(1);
            end
        end
    end

endmodule

// File: rtl/repeat_timer.sv
// repeat_timer: programmable cycle-count timer with one-shot and periodic modes.
// A count N is accepted over a valid/ready handshake; after N count steps a
// one-cycle 'done' pulse is issued, either once or repeatedly with reload.
// Optional feature macro: REPEAT_TIMER_PRESCALE_EN adds the PRESCALE parameter
// so that a count step happens only on every PRESCALE-th RUN edge.
module repeat_timer
    import repeat_timer_pkg::*;
#(
    parameter int CNT_W = 8,
    parameter int PER_W = 8
`ifdef REPEAT_TIMER_PRESCALE_EN
    ,
    parameter int PRESCALE = 1
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [CNT_W-1:0] start_count,
    input  logic             start_mode,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] remaining,
    output logic [PER_W-1:0] periods
);

    repeat_timer_state_e state;
    repeat_timer_mode_e  mode_q;
    logic [CNT_W-1:0]    reload_q;
    logic                accept;
    logic                run_en;
    logic                step;
    logic                final_step;

    assign run_en      = (state == RUN);
    assign start_ready = (state == IDLE);
    assign accept      = (state == IDLE) && start_valid && !abort;
    assign final_step  = step && (remaining == CNT_W'(1));

`ifdef REPEAT_TIMER_PRESCALE_EN
    logic pre_clear;

    assign pre_clear = accept || abort || final_step;

    repeat_timer_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .rst_n(rst_n),
        .clear(pre_clear),
        .run  (run_en),
        .step (step)
    );
`else
    assign step = run_en;
`endif

    // Timer FSM: accept, count down, pulse done, reload or return to IDLE; abort wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mode_q    <= ONE_SHOT;
            reload_q  <= '0;
            remaining <= '0;
            periods   <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        mode_q   <= repeat_timer_mode_e'(start_mode);
                        reload_q <= start_count;
                        if (start_count == '0) begin
                            done    <= 1'b1;
                            periods <= PER_W'(1);
                        end else begin
                            periods   <= '0;
                            remaining <= start_count;
                            state     <= RUN;
                            busy      <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (abort) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        remaining <= '0;
                    end else if (final_step) begin
                        done    <= 1'b1;
                        periods <= periods + PER_W'(1);
                        if (mode_q == PERIODIC) begin
                            remaining <= reload_q;
                        end else begin
                            remaining <= '0;
                            state     <= IDLE;
                            busy      <= 1'b0;
                        end
                    end else if (step) begin
                        remaining <= remaining - CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
